// File: rtl/mutex_pkg.sv
// Shared types and defaults for the round-robin mutex lock arbiter.
// No logic; state encoding and parameter defaults only.
package mutex_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } mutex_arb_state_e;

    localparam int N_REQ_DEF    = 4;
    localparam int HOLD_MAX_DEF = 255;

endpackage

// File: rtl/mutex_arbiter_rr_pick.sv
// Rotate-priority picker: first set req bit after last, wrapping, ending at last.
// Purely combinational, zero latency; no backpressure (always produces a result).
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    int j;

    // Walk offsets from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = (int'(last) + i) % N_REQ;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = IW'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mutex_arbiter.sv
// Round-robin lock arbiter: one-hot grant held until the owner pulses rel.
// Latency: grant one cycle after req is seen; at least one IDLE cycle between owners.
// Backpressure: non-owners wait on req; MUTEX_ARB_TIMEOUT_EN adds a forced-release watchdog.
module mutex_arbiter
    import mutex_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    owner,
    output logic             busy,
    output logic             timeout
);

    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    mutex_arb_state_e state;
    logic [IW-1:0]    last;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic             grant_ok;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

`ifdef MUTEX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          timeout_q;

    assign cnt_nxt  = (cnt == CW'(HOLD_MAX)) ? cnt : cnt + 1'b1;
    assign timeout  = timeout_q;
    // The timeout pulse cycle is spent in IDLE without granting.
    assign grant_ok = pick_vld && !timeout_q;
`else
    logic unused_hold_max;
    assign unused_hold_max = ^HOLD_MAX;
    assign timeout  = 1'b0;
    assign grant_ok = pick_vld;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            last  <= LAST_RST;
`ifdef MUTEX_ARB_TIMEOUT_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MUTEX_ARB_TIMEOUT_EN
                    timeout_q <= 1'b0;
                    cnt       <= '0;
`endif
                    if (grant_ok) begin
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                        last  <= pick_idx;
                        busy  <= 1'b1;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
`ifdef MUTEX_ARB_TIMEOUT_EN
                    cnt <= cnt_nxt;
`endif
                    if (rel[owner]) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`ifdef MUTEX_ARB_TIMEOUT_EN
                    else if (cnt_nxt == CW'(HOLD_MAX)) begin
                        gnt       <= '0;
                        busy      <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mutex_arbiter.sv
// Directed bench for mutex_arbiter; the watchdog section runs when MUTEX_ARB_TIMEOUT_EN is defined.
module tb_mutex_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mutex_arbiter #(.N_REQ(N), .HOLD_MAX(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] e;
        rst = 1'b1;
        req = '0;
        rel = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_timeout", 32'(timeout), 0);

        // Round robin with immediate releases: 0,1,2,3,0
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            tick();
            chk("rr_gnt", 32'(gnt), 32'(e));
            chk("rr_owner", 32'(owner), k % 4);
            chk("rr_busy", 32'(busy), 1);
            rel = e;
            tick();
            rel = '0;
            chk("rr_idle_gnt", 32'(gnt), 0);
            chk("rr_idle_busy", 32'(busy), 0);
        end

        // Requester 1 owns; non-owner release and req changes ignored
        tick();
        chk("no_gnt", 32'(gnt), 32'b0010);
        rel = 4'b0100;
        tick();
        rel = '0;
        chk("no_rel_gnt", 32'(gnt), 32'b0010);
        chk("no_rel_busy", 32'(busy), 1);
        req = 4'b0000;
        tick();
        chk("no_req_drop", 32'(gnt), 32'b0010);
        rel = 4'b0010;
        tick();
        rel = '0;
        chk("no_release", 32'(gnt), 0);

        // Simultaneous rel[owner] and req[owner]: release wins, 3 next
        req = 4'b0001;
        tick();
        chk("sim_own0", 32'(gnt), 32'b0001);
        req = 4'b1001;
        rel = 4'b0001;
        tick();
        rel = '0;
        chk("sim_rel", 32'(gnt), 0);
        tick();
        chk("sim_next", 32'(gnt), 32'b1000);
        chk("sim_owner", 32'(owner), 3);
        req = '0;
        rel = 4'b1000;
        tick();
        rel = '0;
        chk("sim_done", 32'(busy), 0);

`ifndef MUTEX_ARB_TIMEOUT_EN
        // Owner drops req without rel: held indefinitely
        req = 4'b0100;
        tick();
        chk("hold_gnt", 32'(gnt), 32'b0100);
        req = '0;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("hold_long", 32'(gnt), 32'b0100);
        end
        chk("hold_timeout", 32'(timeout), 0);
        rel = 4'b0100;
        tick();
        rel = '0;
        chk("hold_rel", 32'(gnt), 0);
`endif

        // Asynchronous reset mid-lock with requester 2 owning
        req = 4'b0100;
        tick();
        chk("ar_pre_gnt", 32'(gnt), 32'b0100);
        chk("ar_pre_owner", 32'(owner), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_owner", 32'(owner), 0);
        chk("ar_timeout", 32'(timeout), 0);
        req = 4'b1111;
        rst = 1'b0;
        tick();
        chk("ar_post_gnt", 32'(gnt), 32'b0001);
        chk("ar_post_owner", 32'(owner), 0);
        req = '0;
        rel = 4'b0001;
        tick();
        rel = '0;
        chk("ar_post_rel", 32'(gnt), 0);

`ifdef MUTEX_ARB_TIMEOUT_EN
        // Requester 3 holds past HOLD_MAX=10 with requester 0 pending
        req = 4'b1000;
        tick();
        chk("to_gnt", 32'(gnt), 32'b1000);
        req = 4'b1001;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("to_held", 32'(gnt), 32'b1000);
            chk("to_nopulse", 32'(timeout), 0);
        end
        tick();
        chk("to_clear_gnt", 32'(gnt), 0);
        chk("to_clear_busy", 32'(busy), 0);
        chk("to_pulse", 32'(timeout), 1);
        tick();
        chk("to_pulse_end", 32'(timeout), 0);
        chk("to_gap_gnt", 32'(gnt), 0);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'b0001);
        // rel on the limit cycle is a normal release
        for (int k = 0; k < 9; k++) tick();
        chk("to_rel_held", 32'(gnt), 32'b0001);
        rel = 4'b0001;
        tick();
        rel = '0;
        chk("to_rel_gnt", 32'(gnt), 0);
        chk("to_rel_nopulse", 32'(timeout), 0);
        tick();
        chk("to_rel_next", 32'(gnt), 32'b1000);
        req = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mutex_arbiter.md
# mutex_arbiter

Round-robin lock arbiter that shares one `mutex` resource among `N_REQ` requesters. Each requester holds a level request. The arbiter grants exclusive ownership to one requester at a time and holds the grant until that owner pulses release. It sits directly in front of the `mutex` DUT and drives it as the single sequencing master. An optional watchdog forcibly reclaims a lock held too long.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..16.
- `HOLD_MAX`, default 255: maximum cycles a grant is held before forced release. Used only when timeout is compiled in.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, `N_REQ`: level request per requester.
- `rel`, in, `N_REQ`: one-cycle release pulse per requester.
- `gnt`, out, `N_REQ`: one-hot grant, registered.
- `owner`, out, `$clog2(N_REQ)`: index of current owner. Valid only while `busy`=1.
- `busy`, out, 1: lock held.
- `timeout`, out, 1: one-cycle pulse on forced release.

## Operation
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `timeout`=0, state IDLE, `last`=`N_REQ`-1, hold counter=0.
- The `last` initial value of `N_REQ`-1 gives requester 0 top priority after reset.
- FSM has two states, IDLE and LOCKED.
- **IDLE**
  - If any `req` bit is set, pick the first set bit searching `last`+1, `last`+2, … (mod `N_REQ`), ending at `last`.
  - Register `gnt` for the winner, set `owner` to the winner and `last` to the winner, then go to LOCKED.
  - If no `req` bit is set, stay in IDLE.
- **LOCKED**
  - `rel[owner]`=1 clears `gnt` and `busy` and returns to IDLE.
  - `rel` from a non-owner is ignored.
  - `req` changes from anyone, including the owner dropping `req`, are ignored; only `rel` ends ownership.
- Simultaneous `rel[owner]` and `req[owner]`: release wins. The owner re-competes through the rotation, where it now has lowest priority.
- `gnt` stays one-hot or zero in every cycle; there is never more than one grant.
- `rst` asserted mid-lock: all outputs clear immediately (asynchronous), and the pointer returns to its reset value.

## Timing
- Request to grant: `req` sampled high at edge t gives `gnt`/`busy` high after edge t.
- Grant is observable in the cycle after the request is first seen (1-cycle latency).
- Release: `rel[owner]` sampled at edge t clears `gnt` after edge t.
- The next grant is sampled at edge t+1, so there is at least one IDLE cycle between owners.
- Back-to-back handover period is therefore two cycles minimum.
- Timeout (when compiled in):
  - The counter clears on entry to LOCKED and increments every LOCKED cycle.
  - When the counter equals `HOLD_MAX` with no `rel[owner]` in that cycle, the lock is forcibly released: `gnt`/`busy` clear and `timeout`=1 for exactly one cycle, then IDLE.
  - If `rel[owner]` arrives in the same cycle the counter reaches `HOLD_MAX`, it is a normal release and `timeout` stays 0.
  - Counter width is `$clog2(HOLD_MAX+1)`. It saturates and never wraps.

## Configuration
- Macro: `MUTEX_ARB_TIMEOUT_EN`.
- Defined: the hold counter, forced release and `timeout` pulse are present as described in Timing.
- Undefined: there is no counter logic, `timeout` is tied to 0, `HOLD_MAX` is unused, and a lock is held until `rel[owner]` regardless of duration.

## Structure
- Package `mutex_pkg` holds:
  - the state typedef `mutex_arb_state_e` {IDLE, LOCKED};
  - the default `N_REQ` constant;
  - the `HOLD_MAX` default constant.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `req` vector and `last` index.
  - Outputs: one-hot winner, winner index, and a `valid` flag.
  - Instantiated once, in IDLE-path logic.
- Top level contains the FSM, the output registers and the `ifdef`-guarded timeout counter.

## Test plan
- Reset sequencing: assert `rst` mid-cycle while requester 2 owns the lock, with `req`=4'b0100. Outputs must go to 0 immediately. After reset release with `req`=4'b1111, `gnt`=4'b0001 one cycle later.
- Round-robin fairness: hold `req`=4'b1111 and release each grant immediately. The grant sequence must be 0,1,2,3,0, each grant separated by one IDLE cycle.
- Non-owner release: requester 1 owns the lock, pulse `rel`=4'b0100. `gnt` must remain 4'b0010 and `busy` must remain 1.
- Simultaneous release and request: owner 0 pulses `rel[0]` with `req`=4'b1001 held. Next grant must be 4'b1000, never a re-grant to 0.
- Owner drops `req` without `rel`: `gnt` must stay asserted for 100 cycles. This case is run without `MUTEX_ARB_TIMEOUT_EN`.
- Timeout: run with `MUTEX_ARB_TIMEOUT_EN` and `HOLD_MAX`=10, requester 3 holds without releasing. Check `gnt` clears after 10 LOCKED cycles, `timeout` pulses for exactly 1 cycle, and pending requester 0 is granted 2 cycles after `gnt` clears.
